// File: rtl/display_bcd_driver.sv
// display_bcd_driver: signed 32-bit value to eight 7-segment digits plus a
// sign display, using a sequential double-dabble engine (one bit per clock).
// Ports: Clock, ResetN (async, active-low), Valor[31:0] (signed input),
//        Hex0..Hex7 (digit segments {g,f,e,d,c,b,a}, Hex0 = LSD),
//        HexSinal (sign display), Busy (conversion running),
//        Overflow (magnitude above 99,999,999).
// Optional macro LEADING_ZERO_BLANK_EN blanks zeros above the top nonzero digit.
module display_bcd_driver #(
    parameter int WIDTH          = 32,
    parameter int DIGITS         = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic [WIDTH-1:0] Valor,
    output logic [6:0]       Hex0,
    output logic [6:0]       Hex1,
    output logic [6:0]       Hex2,
    output logic [6:0]       Hex3,
    output logic [6:0]       Hex4,
    output logic [6:0]       Hex5,
    output logic [6:0]       Hex6,
    output logic [6:0]       Hex7,
    output logic [6:0]       HexSinal,
    output logic             Busy,
    output logic             Overflow
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  ultimo;
    logic [WIDTH-1:0]  mag;
    logic [39:0]       bcd;
    logic [39:0]       bcd_adj;
    logic [5:0]        cnt;
    logic              neg;
    logic              neg_shown;
    logic [31:0]       digits;
    logic [6:0]        hex_raw [DIGITS];
    logic [6:0]        hex_out [DIGITS];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        unique case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] pol(input logic [6:0] s);
        pol = SEG_ACTIVE_LOW ? s : ~s;
    endfunction

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (Valor != ultimo) state_n = SHIFT;
            SHIFT:   if (cnt == 6'd31)    state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            ultimo    <= '0;
            mag       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            neg_shown <= 1'b0;
            digits    <= '0;
            Busy      <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Valor != ultimo) begin
                        ultimo <= Valor;
                        neg    <= Valor[WIDTH-1];
                        mag    <= Valor[WIDTH-1] ? (~Valor + 1'b1) : Valor;
                        bcd    <= '0;
                        cnt    <= '0;
                        Busy   <= 1'b1;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[38:0], mag[WIDTH-1]};
                    mag <= {mag[WIDTH-2:0], 1'b0};
                    cnt <= cnt + 6'd1;
                end
                DONE: begin
                    Overflow  <= (bcd[39:32] != 8'd0);
                    digits    <= bcd[31:0];
                    neg_shown <= neg;
                    Busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Decode from registered digits only; scan from the top digit down so
    // leading zeros can be suppressed while Hex0 always shows a digit.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hex_raw[i] = seg7(digits[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            lead = lead && (digits[4*i +: 4] == 4'd0);
            if (lead && i != 0) hex_raw[i] = SEG_BLANK;
`endif
            if (Overflow) hex_raw[i] = SEG_DASH;
            hex_out[i] = pol(hex_raw[i]);
        end
    end

    assign Hex0     = hex_out[0];
    assign Hex1     = hex_out[1];
    assign Hex2     = hex_out[2];
    assign Hex3     = hex_out[3];
    assign Hex4     = hex_out[4];
    assign Hex5     = hex_out[5];
    assign Hex6     = hex_out[6];
    assign Hex7     = hex_out[7];
    assign HexSinal = pol(neg_shown ? SEG_DASH : SEG_BLANK);

endmodule

// File: tb/tb_display_bcd_driver.sv
// tb_display_bcd_driver: directed scoreboard bench for display_bcd_driver.
// Expected displays come from a divide/modulo decimal model of the input.
module tb_display_bcd_driver;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] SEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct packed {
        logic [7:0][6:0] hex;
        logic [6:0]      sgn;
        logic            ovf;
    } exp_t;

    logic        Clock;
    logic        ResetN;
    logic [31:0] Valor;
    logic [6:0]  Hex0, Hex1, Hex2, Hex3, Hex4, Hex5, Hex6, Hex7;
    logic [6:0]  HexSinal;
    logic        Busy;
    logic        Overflow;

    int   tests;
    int   fails;
    int   n;
    exp_t q[$];
    exp_t e;

    display_bcd_driver dut (
        .Clock(Clock), .ResetN(ResetN), .Valor(Valor),
        .Hex0(Hex0), .Hex1(Hex1), .Hex2(Hex2), .Hex3(Hex3),
        .Hex4(Hex4), .Hex5(Hex5), .Hex6(Hex6), .Hex7(Hex7),
        .HexSinal(HexSinal), .Busy(Busy), .Overflow(Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic exp_t model(input logic [31:0] v);
        exp_t   r;
        longint m;
        longint p;
        longint d;
        m = v[31] ? (64'sd4294967296 - longint'({32'd0, v})) : longint'({32'd0, v});
        r.ovf = (m > 64'sd99999999);
        r.sgn = v[31] ? DASH : BLANK;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            d = (m / p) % 10;
            r.hex[i] = SEG[int'(d)];
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && m < p) r.hex[i] = BLANK;
`endif
            if (r.ovf) r.hex[i] = DASH;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t o;
        o.hex = {Hex7, Hex6, Hex5, Hex4, Hex3, Hex2, Hex1, Hex0};
        o.sgn = HexSinal;
        o.ovf = Overflow;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = q.pop_front();
            check({tag, "_hex"}, 64'(o.hex), 64'(e.hex));
            check({tag, "_sgn"}, 64'(o.sgn), 64'(e.sgn));
            check({tag, "_ovf"}, 64'(o.ovf), 64'(e.ovf));
        end
    endtask

    // Drive at a negedge, then count negedges until Busy falls.
    // The returned count is busy cycles + 1.
    task automatic run(input logic [31:0] v, input string tag);
        @(negedge Clock);
        Valor = v;
        q.push_back(model(v));
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (Busy && n < 100);
        check({tag, "_busy_cycles"}, 64'(n - 1), 64'd33);
        check_out(tag);
    endtask

    initial begin
        logic busy_seen;
        tests  = 0;
        fails  = 0;
        Valor  = '0;
        ResetN = 1'b0;
        repeat (3) @(negedge Clock);
        #1;
        check("rst_busy", 64'(Busy), 64'd0);
        ResetN = 1'b1;
        busy_seen = 1'b0;
        repeat (50) begin
            @(negedge Clock);
            busy_seen = busy_seen | Busy;
        end
        check("idle_busy", 64'(busy_seen), 64'd0);
        q.push_back(model(32'd0));
        check_out("reset");

        run(32'd1234, "v1234");
        run(32'hFFFF_FFFB, "vneg5");
        run(32'd100000000, "v1e8");
        run(32'd99999999, "v99999999");
        run(32'h8000_0000, "vmin");

        // New value arrives mid-conversion: 7 is shown, then 9 follows.
        @(negedge Clock);
        Valor = 32'd7;
        q.push_back(model(32'd7));
        q.push_back(model(32'd9));
        n = 0;
        repeat (10) begin
            @(negedge Clock);
            n++;
        end
        Valor = 32'd9;
        while (Busy && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("v7_latency", 64'(n), 64'd34);
        check_out("v7");
        n = 0;
        while (!Busy && n < 100) begin
            @(negedge Clock);
            n++;
        end
        while (Busy && n < 200) begin
            @(negedge Clock);
            n++;
        end
        check("v9_latency", 64'(n), 64'd34);
        check_out("v9");

        // Reset during a conversion returns outputs to reset state at once.
        @(negedge Clock);
        Valor = 32'd123;
        repeat (5) @(negedge Clock);
        check("mid_busy", 64'(Busy), 64'd1);
        ResetN = 1'b0;
        #1;
        check("rst_mid_busy", 64'(Busy), 64'd0);
        q.push_back(model(32'd0));
        check_out("rst_mid");
        @(negedge Clock);
        ResetN = 1'b1;
        q.push_back(model(32'd123));
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while ((Busy || n < 2) && n < 100);
        check("v123_latency", 64'(n), 64'd34);
        check_out("v123");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_bcd_driver.md
Name: display_bcd_driver

Overview:
- Downstream consumer of the 32-bit IO output register. Drives the board's eight 7-segment displays plus a sign display.
- Converts the signed two's-complement value to decimal with a sequential double-dabble engine: one bit per clock.
- Automatically re-converts whenever the input value changes. No start strobe from the IO stage is required.

Parameters:
- WIDTH, 32, width of the input value (the logic is written for 32; other values are not supported).
- DIGITS, 8, number of decimal displays driven.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (board default); 0 = inverted polarity.

Ports:
- Clock  input  1  system clock, rising-edge.
- ResetN  input  1  asynchronous, active-low reset.
- Valor  input  32  signed value from the IO output register.
- Hex0..Hex7  output  7 each  segment patterns, bit order {g,f,e,d,c,b,a}; Hex0 is the least significant digit.
- HexSinal  output  7  sign display.
- Busy  output  1  high while a conversion is in progress.
- Overflow  output  1  high when the latched magnitude is greater than 99,999,999.

Behaviour:
- Reset (async, ResetN=0):
  - state=IDLE, Ultimo=0, Busy=0, Overflow=0.
  - Hex0="0" (1000000). Hex1..Hex7 blank (1111111), or "0" if the macro is absent.
  - HexSinal blank.
  - Reset mid-conversion aborts the conversion; nothing partial is ever displayed.
- Internal registers:
  - Ultimo[31:0]: last value accepted.
  - Mag[31:0]: magnitude shift register.
  - Bcd[39:0]: 10 BCD digits, so overflow can be detected.
  - Cnt[5:0]: shift counter.
  - Neg: sign flag.
- IDLE:
  - If Valor != Ultimo at a rising edge: Ultimo<=Valor; Neg<=Valor[31]; Mag<=Valor[31] ? (~Valor+1) : Valor; Bcd<=0; Cnt<=0; Busy<=1; go to SHIFT.
  - Magnitude of 0x80000000 is 2147483648 unsigned; it fits 32 bits and needs no special case.
- SHIFT:
  - Each edge, every Bcd nibble >=5 gets +3, then {Bcd,Mag} shifts left by 1 and Cnt++.
  - After the 32nd shift (Cnt==31 at that edge) go to DONE.
- DONE (one edge):
  - Overflow<=(Bcd[39:32]!=0).
  - Digit registers latch Bcd[31:0].
  - HexSinal<=dash (0111111) if Neg, else blank.
  - Busy<=0; go to IDLE.
- Latency: display updates at the rising edge 33 cycles after the IDLE edge that detected the change. Busy is high for exactly 33 cycles.
- Valor changing while Busy:
  - The value is ignored during conversion; it is never corrupted.
  - After DONE, IDLE compares against Ultimo, so the final stable value is always converted.
  - Intermediate values may be skipped.
- Overflow=1: Hex0..Hex7 all show dash (0111111); HexSinal follows Neg.
- Decoder (active-low):
  - Digits 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - SEG_ACTIVE_LOW=0 inverts all outputs, including blank and dash.
- Outputs are registered or decoded from registered digits only; there is no combinational path from Valor to Hex*.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Zero digits above the most significant nonzero digit are blank; Hex0 always shows a digit.
  - HexSinal dash stays on the dedicated sign display; it is not moved next to the digits.
- Undefined: all eight digits are always shown, including leading zeros (e.g. "00001234").

Test Plan:
- Reset: ResetN low with Valor=0, then release and hold 50 cycles -> Busy stays 0; Hex0=1000000, Hex1..7 blank (macro defined), HexSinal blank, Overflow=0.
- Valor=1234 -> Busy=1 for 33 cycles; then Hex3..Hex0 = 1111001, 0100100, 0110000, 0011001; Hex4..7 blank; HexSinal blank.
- Valor=-5 (0xFFFFFFFB) -> Hex0=0010010, HexSinal=0111111, Overflow=0.
- Valor=100000000 -> Overflow=1, all Hex=0111111. Then Valor=99999999 -> Overflow=0, all eight digits=0010000.
- Valor=0x80000000 -> Overflow=1, HexSinal=dash, all Hex=dash; no hang, Busy drops after 33 cycles.
- Valor=7, then Valor=9 ten cycles later (mid-conversion) -> "7" is displayed at cycle 33; a second conversion then starts and "9" is displayed 34 cycles later. Also assert ResetN mid-conversion -> outputs return to reset values immediately.
